// File: rtl/ram_bus_master.sv
// Burst initiator for the single-port RAM: sequences writes and pipelined reads
// over the shared tri-state data bus; output-enable is exactly the ram_wr_en register.
module ram_bus_master #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int RD_LATENCY = 1,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wr,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_wr_en,
    inout  wire  [DATA_WIDTH-1:0] ram_data
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

    state_t                state, next_state;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [LEN_WIDTH-1:0]  beats_left;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] samp_data;
    logic [RD_LATENCY-1:0] tag_valid, tag_last;
    logic                  samp_valid, samp_last;
    logic                  accept, wr_beat, rd_issue, final_beat, pipe_empty;

    assign ram_data   = ram_wr_en ? wdata : 'z;
    assign final_beat = (beats_left == '0);
    // The sample register counts as in flight: its beat has not reached rd_valid yet.
    assign pipe_empty = !(|tag_valid) && !samp_valid;
    assign cmd_ready  = rst_n && (state == IDLE);
    assign wr_ready   = (state == WRITE);
    assign busy       = (state != IDLE) || !pipe_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        wr_beat    = 1'b0;
        rd_issue   = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    accept     = 1'b1;
                    next_state = cmd_wr ? WRITE : READ;
                end
            end
            WRITE: begin
                if (wr_valid) begin
                    wr_beat = 1'b1;
                    if (final_beat) next_state = IDLE;
                end
            end
            READ: begin
                rd_issue = 1'b1;
                if (final_beat) next_state = DRAIN;
            end
            DRAIN: begin
                if (pipe_empty) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr   <= '0;
            beats_left <= '0;
            ram_addr   <= '0;
            ram_wr_en  <= 1'b0;
            wdata      <= '0;
        end else begin
            ram_wr_en <= wr_beat;
            if (accept) begin
                cur_addr   <= cmd_addr;
                beats_left <= cmd_len;
            end
            if (wr_beat || rd_issue) begin
                ram_addr   <= cur_addr;
                cur_addr   <= cur_addr + 1'b1;
                beats_left <= beats_left - 1'b1;
            end
            if (wr_beat) wdata <= wr_data;
        end
    end

    // Tag pipe: a tag leaving the last stage marks the edge where ram_data is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_valid  <= '0;
            tag_last   <= '0;
            samp_valid <= 1'b0;
            samp_last  <= 1'b0;
            samp_data  <= '0;
            rd_valid   <= 1'b0;
            rd_last    <= 1'b0;
            rd_data    <= '0;
        end else begin
            tag_valid[0] <= rd_issue;
            tag_last[0]  <= rd_issue && final_beat;
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_last[i]  <= tag_last[i-1];
            end
            samp_valid <= tag_valid[RD_LATENCY-1];
            samp_last  <= tag_last[RD_LATENCY-1];
            if (tag_valid[RD_LATENCY-1]) samp_data <= ram_data;
            rd_valid <= samp_valid;
            rd_last  <= samp_valid && samp_last;
            if (samp_valid) rd_data <= samp_data;
        end
    end

endmodule

// File: tb/tb_ram_bus_master.sv
// Drives two masters (RD_LATENCY 1 and 3) with identical commands, each on its own
// RAM model; read beats are scoreboarded with data, last flag and arrival cycle.
module tb_ram_bus_master;

    typedef struct {
        logic [15:0] data;
        logic        last;
        int          cyc;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_wr, wr_valid;
    logic [3:0]  cmd_addr, cmd_len;
    logic [15:0] wr_data;

    logic        cmd_ready1, wr_ready1, rd_valid1, rd_last1, busy1, ram_wr_en1;
    logic [15:0] rd_data1;
    logic [3:0]  ram_addr1;
    wire  [15:0] ram_data1;
    logic        cmd_ready3, wr_ready3, rd_valid3, rd_last3, busy3, ram_wr_en3;
    logic [15:0] rd_data3;
    logic [3:0]  ram_addr3;
    wire  [15:0] ram_data3;

    logic [15:0] mem1 [16];
    logic [15:0] mem3 [16];
    logic [15:0] exp_mem [16];
    logic [15:0] wbuf [16];
    logic [3:0]  a3_d1, a3_d2;
    beat_t       q1[$], q3[$];
    int          cyc = 0, hs = 0, checks = 0, errors = 0, spur = 0, spur_snap = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_bus_master #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .RD_LATENCY(1), .LEN_WIDTH(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready1),
        .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_valid(wr_valid),
        .wr_ready(wr_ready1), .wr_data(wr_data), .rd_valid(rd_valid1), .rd_data(rd_data1),
        .rd_last(rd_last1), .busy(busy1), .ram_addr(ram_addr1), .ram_wr_en(ram_wr_en1),
        .ram_data(ram_data1));

    ram_bus_master #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .RD_LATENCY(3), .LEN_WIDTH(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready3),
        .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_valid(wr_valid),
        .wr_ready(wr_ready3), .wr_data(wr_data), .rd_valid(rd_valid3), .rd_data(rd_data3),
        .rd_last(rd_last3), .busy(busy3), .ram_addr(ram_addr3), .ram_wr_en(ram_wr_en3),
        .ram_data(ram_data3));

    // RAM models: latency 1 reads combinationally, latency 3 delays the address two edges.
    always @(posedge clk) if (ram_wr_en1) mem1[ram_addr1] <= ram_data1;
    assign ram_data1 = ram_wr_en1 ? 'z : mem1[ram_addr1];
    always @(posedge clk) begin
        a3_d1 <= ram_addr3;
        a3_d2 <= a3_d1;
        if (ram_wr_en3) mem3[ram_addr3] <= ram_data3;
    end
    assign ram_data3 = ram_wr_en3 ? 'z : mem3[a3_d2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (rd_valid1) begin
            if (q1.size() == 0) begin
                spur++;
                check("rd1_unexpected_beat", 1, 0);
            end else begin
                e = q1.pop_front();
                check("rd1_data", rd_data1, e.data);
                check("rd1_last", rd_last1, e.last);
                check("rd1_cycle", cyc, e.cyc);
            end
        end
        if (rd_valid3) begin
            if (q3.size() == 0) begin
                spur++;
                check("rd3_unexpected_beat", 1, 0);
            end else begin
                e = q3.pop_front();
                check("rd3_data", rd_data3, e.data);
                check("rd3_last", rd_last3, e.last);
                check("rd3_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 200 && (busy1 || busy3); i++) @(negedge clk);
        check("idle_timeout", {busy1, busy3}, 0);
    endtask

    task automatic send_cmd(input logic wr, input logic [3:0] a, input logic [3:0] l);
        wait_idle();
        check("cmd_ready_idle", {cmd_ready1, cmd_ready3}, 2'b11);
        cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_len = l;
        @(negedge clk);
        cmd_valid = 1'b0;
        hs = cyc;
        check("cmd_ready_after_accept", {cmd_ready1, cmd_ready3}, 2'b00);
    endtask

    task automatic write_burst(input logic [3:0] a, input int n, input int stall_after, input int stall_len);
        send_cmd(1'b1, a, 4'(n - 1));
        for (int i = 0; i < n; i++) begin
            check("wr_ready", {wr_ready1, wr_ready3}, 2'b11);
            wr_valid = 1'b1; wr_data = wbuf[i];
            exp_mem[4'(a + 4'(i))] = wbuf[i];
            @(negedge clk);
            wr_valid = 1'b0;
            if (i == stall_after) begin
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clk);
                    check("stall_wr_en", {ram_wr_en1, ram_wr_en3}, 2'b00);
                    check("stall_addr_hold", ram_addr1, 4'(a + 4'(i)));
                end
            end
        end
    endtask

    task automatic read_burst(input logic [3:0] a, input logic [3:0] l);
        beat_t b;
        send_cmd(1'b0, a, l);
        for (int i = 0; i <= int'(l); i++) begin
            b.data = exp_mem[4'(a + 4'(i))];
            b.last = (i == int'(l));
            b.cyc  = hs + 1 + 2 + i;
            q1.push_back(b);
            b.cyc  = hs + 3 + 2 + i;
            q3.push_back(b);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem1[i] = '0; mem3[i] = '0; exp_mem[i] = '0;
        end
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0;
        repeat (3) @(negedge clk);
        check("rst_wr_en", {ram_wr_en1, ram_wr_en3}, 2'b00);
        check("rst_addr", {ram_addr1, ram_addr3}, 8'h00);
        check("rst_rd", {rd_valid1, rd_last1, rd_valid3, rd_last3}, 4'h0);
        check("rst_rd_data", {rd_data1, rd_data3}, 32'h0);
        check("rst_ready_busy", {cmd_ready1, wr_ready1, busy1, cmd_ready3, wr_ready3, busy3}, 6'h00);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_cmd_ready", {cmd_ready1, cmd_ready3}, 2'b11);

        // Single write: one strobe cycle at addr 3, ready again after the beat edge.
        wbuf[0] = 16'hBEEF;
        write_burst(4'd3, 1, -1, 0);
        check("single_wr_en_on", {ram_wr_en1, ram_wr_en3}, 2'b11);
        check("single_wr_addr", {ram_addr1, ram_addr3}, 8'h33);
        check("single_cmd_ready", {cmd_ready1, cmd_ready3}, 2'b11);
        @(negedge clk);
        check("single_wr_en_off", {ram_wr_en1, ram_wr_en3}, 2'b00);
        check("single_mem1", mem1[3], 16'hBEEF);
        check("single_mem3", mem3[3], 16'hBEEF);

        // Wrapping write burst from 14.
        for (int i = 0; i < 4; i++) wbuf[i] = 16'hA000 + 16'(i);
        write_burst(4'd14, 4, -1, 0);
        wait_idle();
        @(negedge clk);
        check("wrap_mem14", {mem1[14], mem3[14]}, {16'hA000, 16'hA000});
        check("wrap_mem15", {mem1[15], mem3[15]}, {16'hA001, 16'hA001});
        check("wrap_mem0", {mem1[0], mem3[0]}, {16'hA002, 16'hA002});
        check("wrap_mem1", {mem1[1], mem3[1]}, {16'hA003, 16'hA003});

        read_burst(4'd14, 4'd3);

        // Write burst with a two-cycle stall after the second beat.
        for (int i = 0; i < 4; i++) wbuf[i] = 16'hC100 + 16'(i);
        write_burst(4'd8, 4, 1, 2);
        wait_idle();
        @(negedge clk);
        for (int i = 8; i < 12; i++) begin
            check("stall_mem1", mem1[i], exp_mem[i]);
            check("stall_mem3", mem3[i], exp_mem[i]);
        end

        // Write then read of address 5, back to back.
        wbuf[0] = 16'h5A5A;
        write_burst(4'd5, 1, -1, 0);
        read_burst(4'd5, 4'd0);
        for (int i = 0; i < 6; i++) begin
            check("bus_known1", 32'($isunknown(ram_data1)), 0);
            check("bus_known3", 32'($isunknown(ram_data3)), 0);
            @(negedge clk);
        end

        // Longest burst: 16 beats, wrapping from 2.
        read_burst(4'd2, 4'd15);
        wait_idle();

        // Reset during the second address of an 8-beat read.
        send_cmd(1'b0, 4'd0, 4'd7);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_wr_en", {ram_wr_en1, ram_wr_en3}, 2'b00);
        check("abort_rd_valid", {rd_valid1, rd_valid3}, 2'b00);
        check("abort_cmd_ready", {cmd_ready1, cmd_ready3}, 2'b00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        spur_snap = spur;
        @(negedge clk);
        check("release_ready_busy", {cmd_ready1, busy1, cmd_ready3, busy3}, 4'b1010);
        repeat (10) @(negedge clk);
        check("no_stale_rd_valid", spur - spur_snap, 0);

        read_burst(4'd14, 4'd1);
        wait_idle();
        repeat (3) @(negedge clk);
        check("q1_drained", q1.size(), 0);
        check("q3_drained", q3.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
